// File: rtl/nanorv32_flow_ctrl_mc.sv
// nanorv32_flow_ctrl_mc: pipeline flow-control FSM. Decides per cycle whether
// the pipeline advances, stalls or redirects the PC. It handles branch refill
// bubbles, bounded load waits, multi-cycle execute ops and interrupt entry.
module nanorv32_flow_ctrl_mc #(
  parameter int unsigned BRANCH_BUBBLES = 1,
  parameter int unsigned LD_TIMEOUT     = 15,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       branch_taken,
  input  logic       datamem_read,
  input  logic       dataif_cpu_early_ready,
  input  logic       codeif_cpu_ready_r,
  input  logic       mc_req,
  input  logic       mc_done,
  input  logic       irq_req,
  input  logic       irq_en,
  output logic       force_stall_pstate,
  output logic       force_stall_reset,
  output logic       output_new_pc,
  output logic       valid_inst,
  output logic       data_access_cycle,
  output logic       mc_start,
  output logic       irq_ack,
  output logic       load_timeout,
  output logic [2:0] pstate
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_CONT   = 3'd1,
    S_BRANCH = 3'd2,
    S_STALL  = 3'd3,
    S_WAITLD = 3'd4,
    S_MCWAIT = 3'd5,
    S_IRQ    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] BUB_LOAD = CNT_W'(BRANCH_BUBBLES - 1);
  localparam logic [CNT_W-1:0] LD_LAST  = CNT_W'(LD_TIMEOUT - 1);
  localparam bit               LD_TO_EN = (LD_TIMEOUT != 0);

  state_t           state, state_next;
  logic [CNT_W-1:0] bub_cnt, bub_next;
  logic [CNT_W-1:0] wait_cnt, wait_next;

  // State and counter registers; synchronous reset overrides any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      bub_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      bub_cnt  <= bub_next;
      wait_cnt <= wait_next;
    end
  end

  // Next-state, counter updates and per-cycle control outputs.
  always_comb begin
    state_next         = state;
    bub_next           = bub_cnt;
    wait_next          = '0;
    force_stall_pstate = 1'b0;
    force_stall_reset  = 1'b0;
    output_new_pc      = 1'b0;
    valid_inst         = 1'b1;
    data_access_cycle  = 1'b0;
    mc_start           = 1'b0;
    irq_ack            = 1'b0;
    load_timeout       = 1'b0;

    case (state)
      S_RESET: begin
        force_stall_pstate = 1'b1;
        force_stall_reset  = 1'b1;
        state_next         = S_CONT;
      end

      S_CONT: begin
        data_access_cycle = 1'b1;
        if (branch_taken) begin
          output_new_pc      = 1'b1;
          force_stall_pstate = 1'b1;
          bub_next           = BUB_LOAD;
          state_next         = S_BRANCH;
        end else if (mc_req) begin
          mc_start           = 1'b1;
          force_stall_pstate = 1'b1;
          state_next         = S_MCWAIT;
        end else if (datamem_read && dataif_cpu_early_ready) begin
          force_stall_pstate = 1'b1;
          state_next         = S_WAITLD;
        end else if (datamem_read) begin
          force_stall_pstate = 1'b1;
          // Compare against the pre-increment count so the pulse lands on
          // the LD_TIMEOUT-th stalled cycle; the load is then abandoned.
          if (LD_TO_EN && (wait_cnt == LD_LAST)) begin
            load_timeout = 1'b1;
            state_next   = S_WAITLD;
          end else begin
            wait_next  = wait_cnt + 1'b1;
            state_next = S_CONT;
          end
        end else if (irq_req && irq_en) begin
          force_stall_pstate = 1'b1;
          state_next         = S_IRQ;
        end else begin
          state_next = S_CONT;
        end
      end

      S_IRQ: begin
        output_new_pc      = 1'b1;
        irq_ack            = 1'b1;
        force_stall_pstate = 1'b1;
        bub_next           = BUB_LOAD;
        state_next         = S_BRANCH;
      end

      S_BRANCH: begin
        if (bub_cnt != '0) begin
          bub_next = bub_cnt - 1'b1;
        end
        if ((bub_cnt == '0) && codeif_cpu_ready_r) begin
          state_next = S_CONT;
        end else begin
          force_stall_pstate = 1'b1;
          state_next         = S_BRANCH;
        end
      end

      S_WAITLD: begin
        state_next = codeif_cpu_ready_r ? S_CONT : S_STALL;
      end

      S_STALL: begin
        valid_inst = 1'b0;
        if (codeif_cpu_ready_r) begin
          state_next = S_CONT;
        end else begin
          force_stall_pstate = 1'b1;
          state_next         = S_STALL;
        end
      end

      S_MCWAIT: begin
        force_stall_pstate = !mc_done;
        if (mc_done) begin
          state_next = codeif_cpu_ready_r ? S_CONT : S_STALL;
        end else begin
          state_next = S_MCWAIT;
        end
      end

      default: begin
        state_next = S_CONT;
      end
    endcase
  end

  assign pstate = state;

endmodule

// File: tb/tb_nanorv32_flow_ctrl_mc.sv
// Testbench for nanorv32_flow_ctrl_mc: directed scenarios followed by random
// traffic. A driver pushes expected outputs from a behavioural model into a
// queue; a monitor pops and compares them against the DUT every cycle.
module tb_nanorv32_flow_ctrl_mc;

  localparam int BB  = 2;
  localparam int LDT = 4;

  logic clk = 1'b0;
  logic rst, branch_taken, datamem_read, dataif_cpu_early_ready;
  logic codeif_cpu_ready_r, mc_req, mc_done, irq_req, irq_en;
  logic force_stall_pstate, force_stall_reset, output_new_pc, valid_inst;
  logic data_access_cycle, mc_start, irq_ack, load_timeout;
  logic [2:0] pstate;

  always #5 clk = ~clk;

  nanorv32_flow_ctrl_mc #(
    .BRANCH_BUBBLES(BB),
    .LD_TIMEOUT(LDT),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .branch_taken(branch_taken),
    .datamem_read(datamem_read),
    .dataif_cpu_early_ready(dataif_cpu_early_ready),
    .codeif_cpu_ready_r(codeif_cpu_ready_r),
    .mc_req(mc_req),
    .mc_done(mc_done),
    .irq_req(irq_req),
    .irq_en(irq_en),
    .force_stall_pstate(force_stall_pstate),
    .force_stall_reset(force_stall_reset),
    .output_new_pc(output_new_pc),
    .valid_inst(valid_inst),
    .data_access_cycle(data_access_cycle),
    .mc_start(mc_start),
    .irq_ack(irq_ack),
    .load_timeout(load_timeout),
    .pstate(pstate)
  );

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  // Behavioural model: phase numbers follow the documented state codes;
  // bubble and load-wait progress are tracked as plain elapsed-cycle counts.
  int ph = 0;
  int bub_served = 0;
  int ld_stalls = 0;

  function automatic logic [8:0] mk(input logic r, bt, dr, er, rdy, mr, md, ir, ie);
    return {r, bt, dr, er, rdy, mr, md, ir, ie};
  endfunction

  task automatic model_step(input logic [8:0] in, output logic [10:0] e);
    logic r, bt, dr, er, rdy, mr, md, ir, ie;
    logic fsp, fsr, npc, vi, dac, mcs, ack, lto;
    int nph, nserved, nstalls;
    {r, bt, dr, er, rdy, mr, md, ir, ie} = in;
    fsp = 0; fsr = 0; npc = 0; vi = 1; dac = 0; mcs = 0; ack = 0; lto = 0;
    nph = 1; nserved = bub_served; nstalls = 0;
    case (ph)
      0: begin fsp = 1; fsr = 1; nph = 1; end
      1: begin
        dac = 1;
        if (bt) begin npc = 1; fsp = 1; nph = 2; nserved = 0; end
        else if (mr) begin mcs = 1; fsp = 1; nph = 5; end
        else if (dr && er) begin fsp = 1; nph = 4; end
        else if (dr) begin
          fsp = 1;
          if (LDT != 0 && ld_stalls + 1 == LDT) begin lto = 1; nph = 4; end
          else begin nph = 1; nstalls = ld_stalls + 1; end
        end
        else if (ir && ie) begin fsp = 1; nph = 6; end
        else nph = 1;
      end
      6: begin npc = 1; ack = 1; fsp = 1; nph = 2; nserved = 0; end
      2: begin
        if (bub_served + 1 >= BB && rdy) nph = 1;
        else begin fsp = 1; nph = 2; nserved = bub_served + 1; end
      end
      4: nph = rdy ? 1 : 3;
      3: begin
        vi = 0;
        if (rdy) nph = 1;
        else begin fsp = 1; nph = 3; end
      end
      5: begin fsp = !md; nph = md ? (rdy ? 1 : 3) : 5; end
      default: nph = 1;
    endcase
    e = {fsp, fsr, npc, vi, dac, mcs, ack, lto, 3'(ph)};
    if (r) begin ph = 0; bub_served = 0; ld_stalls = 0; end
    else begin ph = nph; bub_served = nserved; ld_stalls = nstalls; end
  endtask

  task automatic cyc(input logic [8:0] in);
    logic [10:0] e;
    @(negedge clk);
    {rst, branch_taken, datamem_read, dataif_cpu_early_ready, codeif_cpu_ready_r,
     mc_req, mc_done, irq_req, irq_en} = in;
    model_step(in, e);
    exp_q.push_back(e);
  endtask

  task automatic rand_cyc(input int er_pct);
    cyc(mk($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 35, $urandom_range(0, 99) < er_pct,
           $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 70));
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  initial begin
    logic [10:0] e, a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {force_stall_pstate, force_stall_reset, output_new_pc, valid_inst,
             data_access_cycle, mc_start, irq_ack, load_timeout, pstate};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got fsp/fsr/npc/vi/dac/mcs/ack/lto=%b pstate=%0d expected %b pstate=%0d",
                   $time, a[10:3], a[2:0], e[10:3], e[2:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    {rst, branch_taken, datamem_read, dataif_cpu_early_ready, codeif_cpu_ready_r,
     mc_req, mc_done, irq_req, irq_en} = mk(1, 0, 0, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    // Reset held two cycles, then released.
    repeat (2) cyc(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
    repeat (2) cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Branch with ready tied high.
    cyc(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
    repeat (4) cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Load that never gets early_ready: timeout on the 4th stalled cycle.
    repeat (LDT) cyc(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
    repeat (3) cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Load with immediate early_ready.
    cyc(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    repeat (3) cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Multi-cycle op finishing while code interface is not ready.
    cyc(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    repeat (4) cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    repeat (2) cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Branch and interrupt together: branch wins, interrupt follows.
    cyc(mk(0, 1, 0, 0, 1, 0, 0, 1, 1));
    repeat (7) cyc(mk(0, 0, 0, 0, 1, 0, 0, 1, 1));
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Reset in the middle of MCWAIT, after a partial load wait.
    repeat (2) cyc(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
    cyc(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    repeat (2) cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    cyc(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    repeat (2) cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    repeat (LDT + 1) cyc(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
    repeat (2) cyc(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Random traffic: mixed, then with early_ready mostly low to hit timeouts.
    repeat (2000) rand_cyc(50);
    repeat (2000) rand_cyc(5);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
